// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer sequencer: note codes, half-period
// constants, melody ROM, FSM state encoding and small helper functions.
package buzzer_pkg;

  typedef logic [2:0] note_t;

  localparam note_t NOTE_REST = 3'd0;
  localparam note_t NOTE_DO   = 3'd1;
  localparam note_t NOTE_RE   = 3'd2;
  localparam note_t NOTE_MI   = 3'd3;
  localparam note_t NOTE_FA   = 3'd4;
  localparam note_t NOTE_SOL  = 3'd5;
  localparam note_t NOTE_LA   = 3'd6;
  localparam note_t NOTE_SI   = 3'd7;

  // Half-period of each note in 50 MHz clock cycles.
  localparam logic [15:0] HALF_DO  = 16'd47778;
  localparam logic [15:0] HALF_RE  = 16'd42565;
  localparam logic [15:0] HALF_MI  = 16'd37921;
  localparam logic [15:0] HALF_FA  = 16'd35793;
  localparam logic [15:0] HALF_SOL = 16'd31888;
  localparam logic [15:0] HALF_LA  = 16'd28409;
  localparam logic [15:0] HALF_SI  = 16'd25310;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Unshifted half-period for a note code; a rest has no period.
  function automatic logic [15:0] half_of(input note_t code);
    case (code)
      NOTE_DO:  return HALF_DO;
      NOTE_RE:  return HALF_RE;
      NOTE_MI:  return HALF_MI;
      NOTE_FA:  return HALF_FA;
      NOTE_SOL: return HALF_SOL;
      NOTE_LA:  return HALF_LA;
      NOTE_SI:  return HALF_SI;
      default:  return 16'd0;
    endcase
  endfunction

  // Melody ROM: note code for melody id at note position idx.
  function automatic note_t melody_note(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b00_00: return NOTE_SOL;
      4'b00_01: return NOTE_MI;
      4'b00_10: return NOTE_SOL;
      4'b00_11: return NOTE_MI;
      4'b01_00: return NOTE_DO;
      4'b01_01: return NOTE_MI;
      4'b01_10: return NOTE_SOL;
      4'b01_11: return NOTE_REST;
      4'b10_00: return NOTE_MI;
      4'b10_01: return NOTE_REST;
      4'b10_10: return NOTE_REST;
      4'b10_11: return NOTE_REST;
      4'b11_00: return NOTE_SOL;
      4'b11_01: return NOTE_MI;
      4'b11_10: return NOTE_DO;
      4'b11_11: return NOTE_REST;
      default:  return NOTE_REST;
    endcase
  endfunction

  // Fixed-priority pick: index of the lowest set request bit.
  function automatic logic [1:0] first_set(input logic [3:0] v);
    if (v[0]) begin
      return 2'd0;
    end else if (v[1]) begin
      return 2'd1;
    end else if (v[2]) begin
      return 2'd2;
    end else if (v[3]) begin
      return 2'd3;
    end else begin
      return 2'd0;
    end
  endfunction

endpackage

// File: rtl/buzzer_sequencer_if.sv
// Request/status bundle between the sound requesters and the sequencer.
interface buzzer_sequencer_if;
  logic [3:0] req;
  logic       stop;
  logic       buzzer;
  logic       busy;
  logic [1:0] active_id;
  logic       done;

  modport master (
    output req,
    output stop,
    input  buzzer,
    input  busy,
    input  active_id,
    input  done
  );

  modport slave (
    input  req,
    input  stop,
    output buzzer,
    output busy,
    output active_id,
    output done
  );
endinterface

// File: rtl/buzzer_tone_gen.sv
// Square-wave generator: toggles its output every half-period of the current
// note. Load (held or pulsed) parks the counter at 0 with the output low.
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int unsigned DIV_SHIFT = 0
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_load,
  input  note_t i_code,
  output logic  o_wave
);

  logic [15:0] r_cnt;
  logic        r_wave;
  logic [15:0] w_half;
  logic [15:0] w_half_m1;

  assign w_half    = half_of(i_code) >> DIV_SHIFT;
  assign w_half_m1 = w_half - 16'd1;
  assign o_wave    = r_wave;

  // Half-period counter and output toggle; rests keep the output low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= 16'd0;
      r_wave <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= 16'd0;
      r_wave <= 1'b0;
    end else if (i_code == NOTE_REST) begin
      r_cnt  <= 16'd0;
      r_wave <= 1'b0;
    end else if (r_cnt == w_half_m1) begin
      r_cnt  <= 16'd0;
      r_wave <= ~r_wave;
    end else begin
      r_cnt  <= r_cnt + 16'd1;
      r_wave <= r_wave;
    end
  end

endmodule

// File: rtl/buzzer_sequencer.sv
// Buzzer sequencer: latches sound requests, grants the lowest pending id
// when idle, and plays its 4-note melody (note, gap, note, gap, ...).
module buzzer_sequencer
  import buzzer_pkg::*;
#(
  parameter int unsigned NOTE_CYC  = 10_000_000,
  parameter int unsigned GAP_CYC   = 1_000_000,
  parameter int unsigned DIV_SHIFT = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  buzzer_sequencer_if.slave   io_bus
);

  localparam logic [23:0] NOTE_LOAD = 24'(NOTE_CYC - 32'd1);
  localparam logic [23:0] GAP_LOAD  = 24'(GAP_CYC - 32'd1);

  state_t      r_state;
  logic [3:0]  r_pending;
  logic [1:0]  r_note;
  logic [23:0] r_dur;
  logic [1:0]  r_id;
  logic        r_busy;
  logic        r_done;

  logic [1:0]  w_grant_id;
  logic [3:0]  w_clear;
  logic        w_load;
  note_t       w_code;
  logic        w_wave;

  assign w_grant_id = first_set(r_pending);

  // Pending bits consumed by a grant this cycle (only possible in IDLE).
  always_comb begin
    w_clear = 4'b0000;
    if ((r_state == ST_IDLE) && (r_pending != 4'b0000)) begin
      w_clear = 4'b0001 << w_grant_id;
    end else begin
      w_clear = 4'b0000;
    end
  end

  // Tone is restarted on every PLAY entry and silenced outside PLAY.
  assign w_load = (r_state != ST_PLAY) | (r_dur == 24'd0) | io_bus.stop;
  assign w_code = melody_note(r_id, r_note);

  // Arbiter, pending register, duration counter and sequencing FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_pending <= 4'b0000;
      r_note    <= 2'd0;
      r_dur     <= 24'd0;
      r_id      <= 2'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (io_bus.stop) begin
      r_state   <= ST_IDLE;
      r_pending <= 4'b0000;
      r_note    <= 2'd0;
      r_dur     <= 24'd0;
      r_id      <= 2'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clear) | io_bus.req;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_pending != 4'b0000) begin
            r_state <= ST_PLAY;
            r_note  <= 2'd0;
            r_dur   <= NOTE_LOAD;
            r_id    <= w_grant_id;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (r_dur == 24'd0) begin
            r_state <= ST_GAP;
            r_dur   <= GAP_LOAD;
          end else begin
            r_dur   <= r_dur - 24'd1;
          end
        end
        ST_GAP: begin
          if (r_dur == 24'd0) begin
            if (r_note == 2'd3) begin
              r_state <= ST_IDLE;
              r_note  <= 2'd0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_id    <= 2'd0;
            end else begin
              r_state <= ST_PLAY;
              r_note  <= r_note + 2'd1;
              r_dur   <= NOTE_LOAD;
            end
          end else begin
            r_dur <= r_dur - 24'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_note  <= 2'd0;
          r_dur   <= 24'd0;
          r_id    <= 2'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  buzzer_tone_gen #(
    .DIV_SHIFT (DIV_SHIFT)
  ) u_tone (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .i_code (w_code),
    .o_wave (w_wave)
  );

  assign io_bus.buzzer    = w_wave;
  assign io_bus.busy      = r_busy;
  assign io_bus.active_id = r_id;
  assign io_bus.done      = r_done;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench for buzzer_sequencer: a reset/latency vector table plus hand-written
// sequences; an event scoreboard holds the required change cycle and value of
// every output, derived from the melody table and note timing.
module tb_buzzer_sequencer;

  localparam int NOTE  = 2000;
  localparam int GAP   = 100;
  localparam int SHIFT = 8;
  localparam int MEL   = 4 * (NOTE + GAP);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  buzzer_sequencer_if bus_if ();

  buzzer_sequencer #(
    .NOTE_CYC  (NOTE),
    .GAP_CYC   (GAP),
    .DIV_SHIFT (SHIFT)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus_if)
  );

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  typedef struct {
    logic       rst;
    logic       stop;
    logic [3:0] req;
    logic       buz;
    logic       busy;
    logic [1:0] id;
    logic       done;
  } vec_t;

  // Output index: 0 buzzer, 1 busy, 2 active_id, 3 done.
  ev_t evq [4][$];
  int  exp_tail   [4];
  int  popped_val [4];
  int  prev_out   [4];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  busy_cycles = 0;

  int HALF_TAB [8] = '{0, 47778, 42565, 37921, 35793, 31888, 28409, 25310};
  int MEL_TAB [4][4] = '{'{5, 3, 5, 3}, '{1, 3, 5, 0}, '{3, 0, 0, 0}, '{5, 3, 1, 0}};
  string names [4] = '{"buzzer", "busy", "active_id", "done"};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int out_val(input int s);
    case (s)
      0: return int'(bus_if.buzzer);
      1: return int'(bus_if.busy);
      2: return int'(bus_if.active_id);
      3: return int'(bus_if.done);
      default: return 0;
    endcase
  endfunction

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic push_ev(input int s, input int c, input int v);
    ev_t e;
    if (v != exp_tail[s]) begin
      e.cyc = c;
      e.val = v;
      evq[s].push_back(e);
      exp_tail[s] = v;
    end
  endtask

  // Expected output changes for melody id granted at edge g; returns end edge.
  task automatic add_melody(input int g, input int id, output int e_cyc);
    int gp, h, b, code;
    push_ev(1, g, 1);
    push_ev(2, g, id);
    for (int p = 0; p < 4; p++) begin
      gp   = g + p * (NOTE + GAP);
      code = MEL_TAB[id][p];
      if (code != 0) begin
        h = HALF_TAB[code] >> SHIFT;
        b = 0;
        for (int k = 1; k * h <= NOTE - 1; k++) begin
          b = b ^ 1;
          push_ev(0, gp + k * h, b);
        end
      end
      push_ev(0, gp + NOTE, 0);
    end
    e_cyc = g + MEL;
    push_ev(1, e_cyc, 0);
    push_ev(2, e_cyc, 0);
    push_ev(3, e_cyc, 1);
    push_ev(3, e_cyc + 1, 0);
  endtask

  // Abort at edge s_cyc: drop later expectations, all outputs 0 from then on.
  task automatic truncate(input int s_cyc);
    for (int s = 0; s < 4; s++) begin
      while (evq[s].size() > 0 && evq[s][evq[s].size() - 1].cyc >= s_cyc)
        void'(evq[s].pop_back());
      if (evq[s].size() > 0) exp_tail[s] = evq[s][evq[s].size() - 1].val;
      else exp_tail[s] = popped_val[s];
      push_ev(s, s_cyc, 0);
    end
  endtask

  task automatic check_change(input int s, input int v);
    ev_t e;
    checks++;
    if (evq[s].size() == 0) begin
      errors++;
      $display("FAIL %s: changed to %0d at cycle %0d, required no change", names[s], v, cyc);
    end else begin
      e = evq[s].pop_front();
      popped_val[s] = e.val;
      if (e.cyc != cyc || e.val != v) begin
        errors++;
        $display("FAIL %s: changed to %0d at cycle %0d, required %0d at cycle %0d",
                 names[s], v, cyc, e.val, e.cyc);
      end
    end
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outs(input string name, input int buz, input int busy, input int id, input int done);
    check_eq({name, ".buzzer"}, int'(bus_if.buzzer), buz);
    check_eq({name, ".busy"}, int'(bus_if.busy), busy);
    check_eq({name, ".active_id"}, int'(bus_if.active_id), id);
    check_eq({name, ".done"}, int'(bus_if.done), done);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus_if.busy === 1'b1) busy_cycles++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // Output-change monitor feeding the scoreboard.
  initial begin
    int v;
    for (int s = 0; s < 4; s++) begin
      prev_out[s] = 0;
      exp_tail[s] = 0;
      popped_val[s] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 4; s++) begin
        v = out_val(s);
        if (v != prev_out[s]) begin
          check_change(s, v);
          prev_out[s] = v;
        end
      end
    end
  end

  initial begin
    vec_t tab [6];
    int g, e1, e2, e3;

    bus_if.req  = 4'b0000;
    bus_if.stop = 1'b0;

    tab[0] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
    tab[1] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
    tab[2] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
    tab[3] = '{1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0};
    tab[4] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0};
    tab[5] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0};

    // Reset state and request-to-grant latency (melody 2).
    g = 0;
    e1 = 0;
    for (int i = 0; i < 6; i++) begin
      rst         = tab[i].rst;
      bus_if.stop = tab[i].stop;
      bus_if.req  = tab[i].req;
      if (tab[i].req != 4'b0000) begin
        g = cyc + 2;
        add_melody(g, lowest(tab[i].req), e1);
      end
      step();
      check_outs($sformatf("vec%0d", i), int'(tab[i].buz), int'(tab[i].busy),
                 int'(tab[i].id), int'(tab[i].done));
    end
    // Rest notes keep the buzzer low while the melody is still busy.
    run_to(g + (NOTE + GAP) + 1000);
    check_outs("rest_note1", 0, 1, 2, 0);
    run_to(g + 3 * (NOTE + GAP) + NOTE - 1);
    check_outs("rest_note3_end", 0, 1, 2, 0);
    run_to(e1 + 3);

    // Simultaneous req[3] and req[0]: melody 0 then melody 3 back to back.
    bus_if.req = 4'b1001;
    add_melody(cyc + 2, 0, e1);
    add_melody(e1 + 1, 3, e2);
    step();
    bus_if.req = 4'b0000;
    run_to(e1);
    check_outs("b2b_done", 0, 0, 0, 1);
    step();
    check_outs("b2b_second_grant", 0, 1, 3, 0);
    run_to(e2 + 3);

    // Three re-requests of melody 1 during its playback merge into one replay.
    bus_if.req = 4'b0010;
    g = cyc + 2;
    add_melody(g, 1, e1);
    add_melody(e1 + 1, 1, e2);
    step();
    bus_if.req = 4'b0000;
    busy_cycles = 0;
    run_to(g + 100);
    bus_if.req = 4'b0010;
    step();
    bus_if.req = 4'b0000;
    run_to(g + 3000);
    bus_if.req = 4'b0010;
    step();
    bus_if.req = 4'b0000;
    run_to(g + 8000);
    bus_if.req = 4'b0010;
    step();
    bus_if.req = 4'b0000;
    run_to(e2 + 3);
    check_eq("replay_busy_cycles", busy_cycles, 2 * MEL);

    // stop mid note 2 of melody 1 with a replay pending.
    bus_if.req = 4'b0010;
    g = cyc + 2;
    add_melody(g, 1, e1);
    step();
    bus_if.req = 4'b0000;
    run_to(g + 1000);
    bus_if.req = 4'b0010;
    step();
    bus_if.req = 4'b0000;
    run_to(g + (NOTE + GAP) + 500);
    bus_if.stop = 1'b1;
    truncate(cyc + 1);
    step();
    bus_if.stop = 1'b0;
    check_outs("after_stop", 0, 0, 0, 0);
    run_to(cyc + 200);
    check_outs("stop_no_replay", 0, 0, 0, 0);
    bus_if.req = 4'b0010;
    g = cyc + 2;
    add_melody(g, 1, e3);
    step();
    bus_if.req = 4'b0000;
    run_to(g + 185);
    check_eq("restart_do_before_toggle", int'(bus_if.buzzer), 0);
    step();
    check_eq("restart_do_first_toggle", int'(bus_if.buzzer), 1);
    run_to(e3 + 3);

    // Reset mid-melody with req[0] held high.
    bus_if.req = 4'b0001;
    g = cyc + 2;
    add_melody(g, 0, e1);
    run_to(g + 3000);
    rst = 1'b1;
    truncate(cyc + 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_outs($sformatf("in_reset%0d", i), 0, 0, 0, 0);
    end
    rst = 1'b0;
    add_melody(cyc + 2, 0, e2);
    step();
    bus_if.req = 4'b0000;
    check_eq("post_reset_not_yet_busy", int'(bus_if.busy), 0);
    step();
    check_outs("post_reset_grant", 0, 1, 0, 0);
    run_to(e2 + 3);

    run_to(cyc + 10);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (evq[s].size() != 0) begin
        errors++;
        $display("FAIL %s_events: %0d required changes never seen, next at cycle %0d value %0d",
                 names[s], evq[s].size(), evq[s][0].cyc, evq[s][0].val);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzzer_sequencer.md
Name: buzzer_sequencer

Overview:
- Shares the single board buzzer between four sound requesters: alarm, feed, button test and reset.
- Each requester owns a fixed 4-note melody; the sequencer arbitrates pending requests, plays one melody at a time note by note with gaps, and drives the buzzer pin.
- Sits between the game FSM / button debouncers and the buzzer output pin.

Parameters:
- NOTE_CYC, 10_000_000, clock cycles per note (200 ms at 50 MHz)
- GAP_CYC, 1_000_000, silent clock cycles after each note (20 ms)
- DIV_SHIFT, 0, right shift applied to every half-period constant (simulation speed-up)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- req  in  4  request lines; req[0]=alarm, req[1]=feed, req[2]=btn_test, req[3]=reset sound; any cycle high registers a request
- stop  in  1  abort the current melody and clear all pending requests
- buzzer  out  1  square-wave output to the buzzer
- busy  out  1  high while a melody is playing
- active_id  out  2  index of the melody playing; 0 when idle
- done  out  1  one-cycle pulse when a melody completes normally

Behaviour:
- Reset (rst=1 at an edge): state IDLE, pending=0, note_idx=0, counters=0, buzzer=0, busy=0, active_id=0, done=0 from the next cycle. Reset mid-melody aborts immediately with no done pulse.
- Pending register:
  - pending[i] is set on any edge where req[i]=1.
  - It is cleared on the edge that grants melody i.
  - A req[i] that coincides with its own grant edge stays set, so one replay is queued. Further requests while pending merge, giving at most one queued replay per id.
- Arbitration: fixed priority, lowest index wins, evaluated only in IDLE. There is no preemption.
- FSM states: IDLE, PLAY, GAP.
  - IDLE: if pending!=0, grant the lowest set bit. Go to PLAY with note_idx=0, dur_cnt=NOTE_CYC-1, busy=1, active_id=id.
  - PLAY: tone generator drives buzzer from the current note code. dur_cnt counts down; at 0, go to GAP with dur_cnt=GAP_CYC-1 and buzzer=0.
  - GAP: buzzer=0. At dur_cnt 0:
    - if note_idx==3, go to IDLE, done=1 for one cycle, busy=0, active_id=0;
    - otherwise note_idx+1 and go to PLAY with dur_cnt=NOTE_CYC-1.
- Latency: req high at edge t gives pending at t, grant at t+1 (state=PLAY, busy=1 after edge t+1).
- Note timing: each note occupies exactly NOTE_CYC cycles in PLAY and GAP_CYC cycles in GAP. A full melody is 4*(NOTE_CYC+GAP_CYC) cycles.
- Back-to-back melodies: if another request is pending, IDLE lasts exactly one cycle between them; the done pulse falls in that cycle.
- stop: takes priority over req in the same cycle. It forces IDLE, clears pending, sets buzzer=0 and busy=0 on the next edge, with no done pulse.
- Tone generation:
  - 16-bit counter; half = HALF[code]>>DIV_SHIFT.
  - On entering PLAY, counter=0 and buzzer=0.
  - Each cycle the counter increments. When counter==half-1, the counter returns to 0 and buzzer toggles.
  - Code 0 is a rest: buzzer held 0 for the note duration.
- Melody ROM (note codes):
  - id0 = SOL,MI,SOL,MI
  - id1 = DO,MI,SOL,REST
  - id2 = MI,REST,REST,REST
  - id3 = SOL,MI,DO,REST
- Half-period constants (cycles at 50 MHz):
  - 1 DO 47_778
  - 2 RE 42_565
  - 3 MI 37_921
  - 4 FA 35_793
  - 5 SOL 31_888
  - 6 LA 28_409
  - 7 SI 25_310
- Width rules: half-period and tone counter are 16 bits; dur_cnt is 24 bits. GAP_CYC>=1 and NOTE_CYC>=1 are required.

Decomposition:
- Shared package buzzer_pkg holds:
  - note codes (3-bit)
  - HALF_* half-period constants
  - melody ROM contents
  - FSM state encoding
- One sub-module, buzzer_tone_gen (inputs clk, rst, load, note code; output square wave), instantiated once.
- Arbiter, duration counters and FSM stay in the top level.

Test Plan (NOTE_CYC=2000, GAP_CYC=100, DIV_SHIFT=8):
- req[2] one-cycle pulse in IDLE -> busy rises 1 cycle later, active_id=2. Buzzer toggles every 148 cycles for 2000 cycles, then stays 0 for 3*2100+100 cycles. done pulses once 8400 cycles after grant.
- req[3] and req[0] in the same cycle -> melody 0 plays first (first note toggles every 124 cycles), then after a 1-cycle IDLE melody 3 runs with active_id=3; two done pulses.
- req[1] re-asserted during its own playback, 3 times -> exactly one replay follows; total busy time 2*8400 cycles plus 1 idle cycle.
- stop asserted mid-note 2 of melody 1 -> next edge: buzzer=0, busy=0, pending=0, no done pulse. A later req[1] restarts from note 0 (DO, 186-cycle half-period).
- rst asserted mid-melody with req[0] held high -> outputs 0 while rst=1. After release, melody 0 grants 1 cycle after the first sampled request.
- Rest notes (melody 2, notes 1-3) -> buzzer constant 0 for each full NOTE_CYC while busy stays 1.
